// File: rtl/bus_uart_tx_pkg.sv
// Shared definitions for the bus UART transmitter: register offsets,
// STATUS bit positions and the bus / transmit state encodings.
package bus_uart_tx_defs;

    localparam logic [1:0] REG_DATA    = 2'd0;
    localparam logic [1:0] REG_STATUS  = 2'd1;
    localparam logic [1:0] REG_DIVISOR = 2'd2;
    localparam logic [1:0] REG_IRQCTL  = 2'd3;

    localparam int STAT_FULL      = 0;
    localparam int STAT_EMPTY     = 1;
    localparam int STAT_BUSY      = 2;
    localparam int STAT_COUNT_LSB = 8;

    typedef enum logic [1:0] {BUS_IDLE, BUS_ACK, BUS_GAP} bus_state_t;
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

    // A zero divisor would stall the baud counter, so it is stored as 1.
    function automatic logic [15:0] clamp_divisor(input logic [15:0] d);
        return (d == 16'd0) ? 16'd1 : d;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous first-word-fall-through FIFO feeding the UART transmitter.
// Simultaneous push and pop always both succeed, even when full or empty.
module uart_tx_fifo #(
    parameter int DEPTH_LOG2 = 4,
    parameter int WIDTH      = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic [WIDTH-1:0]      din,
    output logic [WIDTH-1:0]      dout,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic                  do_push;
    logic                  do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_COUNT);
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && (!empty || push);
    // An empty FIFO passes din straight through so a same-cycle pop sees it.
    assign dout    = empty ? din : mem[rd_ptr];

    // NOTE: the storage array has no reset; its contents are only visible
    // behind count, which is reset, so clearing it would buy nothing.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its inputs from before the edge, whatever the statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/bus_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the shared system bus.
// Optional interrupt output enabled by defining BUS_UART_TX_IRQ_EN.
module bus_uart_tx
    import bus_uart_tx_defs::*;
#(
    parameter logic [31:0] BASE_ADDR       = 32'h8000_0000,
    parameter logic [15:0] CLK_DIV         = 16'd868,
    parameter int          FIFO_DEPTH_LOG2 = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] bus_addr,
    input  logic [31:0] bus_wdata,
    input  logic        bus_rd,
    input  logic        bus_wr,
    output logic [31:0] bus_rdata,
    output logic        bus_ready,
    output logic        txd
`ifdef BUS_UART_TX_IRQ_EN
    ,
    output logic        irq
`endif
);

    bus_state_t bus_state, bus_next;
    tx_state_t  tx_state, tx_next;

    logic                     hit, capture, commit;
    logic [1:0]               reg_off, req_off;
    logic                     req_wr;
    logic [15:0]              req_wdata;
    logic [31:0]              read_val, rdata_q;
    logic [15:0]              divisor;
    logic                     fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [7:0]               fifo_dout;
    logic [FIFO_DEPTH_LOG2:0] fifo_count;
    logic                     tx_busy;
    logic [15:0]              baud_cnt, cnt_next, bit_div, div_next;
    logic [2:0]               bit_idx, idx_next;
    logic [7:0]               shreg, shreg_next;
    logic                     load_frame, txd_next;
    logic                     irq_en_bit;
    logic                     unused_bits;

    assign unused_bits = ^{bus_addr[1:0], bus_wdata[31:16]};

    assign hit       = (bus_addr[31:4] == BASE_ADDR[31:4]);
    assign reg_off   = bus_addr[3:2];
    assign commit    = (bus_state == BUS_ACK) && req_wr;
    assign fifo_push = commit && (req_off == REG_DATA);
    assign tx_busy   = (tx_state != TX_IDLE);
    assign bus_ready = (bus_state == BUS_ACK);
    assign bus_rdata = bus_ready ? rdata_q : 32'd0;

    uart_tx_fifo #(.DEPTH_LOG2(FIFO_DEPTH_LOG2), .WIDTH(8)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (req_wdata[7:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // A DATA write into a full FIFO is held off here until a slot frees.
    // NOTE: every combinational output gets a default first so no path
    // through the case statement can leave a value held (no latches).
    always_comb begin
        bus_next = bus_state;
        capture  = 1'b0;
        case (bus_state)
            BUS_IDLE:
                if (hit && (bus_rd || bus_wr) &&
                    !(bus_wr && (reg_off == REG_DATA) && fifo_full)) begin
                    bus_next = BUS_ACK;
                    capture  = 1'b1;
                end
            BUS_ACK: bus_next = BUS_GAP;
            BUS_GAP: bus_next = BUS_IDLE;
            default: bus_next = BUS_IDLE;
        endcase
    end

    always_comb begin
        read_val = 32'd0;
        case (reg_off)
            REG_STATUS: begin
                read_val[STAT_FULL]                = fifo_full;
                read_val[STAT_EMPTY]               = fifo_empty;
                read_val[STAT_BUSY]                = tx_busy;
                read_val[STAT_COUNT_LSB +: 8]      = 8'(fifo_count);
            end
            REG_DIVISOR: read_val[15:0] = divisor;
            REG_IRQCTL:  read_val[0]    = irq_en_bit;
            default:     read_val       = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) bus_state <= BUS_IDLE;
        else     bus_state <= bus_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            req_wr    <= 1'b0;
            req_off   <= REG_DATA;
            req_wdata <= 16'd0;
            rdata_q   <= 32'd0;
            divisor   <= CLK_DIV;
        end else begin
            if (capture) begin
                req_wr    <= bus_wr;
                req_off   <= reg_off;
                req_wdata <= bus_wdata[15:0];
                rdata_q   <= bus_wr ? 32'd0 : read_val;
            end
            if (commit && (req_off == REG_DIVISOR))
                divisor <= clamp_divisor(req_wdata);
        end
    end

`ifdef BUS_UART_TX_IRQ_EN
    logic irq_en;
    assign irq_en_bit = irq_en;

    always_ff @(posedge clk) begin
        if (rst) begin
            irq_en <= 1'b0;
            irq    <= 1'b0;
        end else begin
            if (commit && (req_off == REG_IRQCTL)) irq_en <= req_wdata[0];
            irq <= irq_en && fifo_empty && !tx_busy;
        end
    end
`else
    assign irq_en_bit = 1'b0;
`endif

    // Divisor is latched per frame so a DIVISOR write never disturbs a frame in flight.
    always_comb begin
        tx_next    = tx_state;
        cnt_next   = baud_cnt - 16'd1;
        idx_next   = bit_idx;
        shreg_next = shreg;
        div_next   = bit_div;
        load_frame = 1'b0;
        txd_next   = 1'b1;
        case (tx_state)
            TX_IDLE: begin
                cnt_next   = baud_cnt;
                load_frame = !fifo_empty;
            end
            TX_START:
                if (baud_cnt == 16'd0) begin
                    tx_next  = TX_DATA;
                    idx_next = 3'd0;
                    cnt_next = bit_div - 16'd1;
                end
            TX_DATA:
                if (baud_cnt == 16'd0) begin
                    cnt_next = bit_div - 16'd1;
                    if (bit_idx == 3'd7) tx_next  = TX_STOP;
                    else                 idx_next = bit_idx + 3'd1;
                end
            TX_STOP:
                if (baud_cnt == 16'd0) begin
                    if (!fifo_empty) load_frame = 1'b1;
                    else             tx_next    = TX_IDLE;
                end
            default: tx_next = TX_IDLE;
        endcase
        if (load_frame) begin
            tx_next    = TX_START;
            shreg_next = fifo_dout;
            div_next   = divisor;
            cnt_next   = divisor - 16'd1;
        end
        fifo_pop = load_frame;
        case (tx_next)
            TX_START: txd_next = 1'b0;
            TX_DATA:  txd_next = shreg_next[idx_next];
            default:  txd_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state <= TX_IDLE;
            baud_cnt <= 16'd0;
            bit_idx  <= 3'd0;
            shreg    <= 8'd0;
            bit_div  <= CLK_DIV;
            txd      <= 1'b1;
        end else begin
            tx_state <= tx_next;
            baud_cnt <= cnt_next;
            bit_idx  <= idx_next;
            shreg    <= shreg_next;
            bit_div  <= div_next;
            txd      <= txd_next;
        end
    end

endmodule

// File: tb/tb_bus_uart_tx.sv
// Self-checking bench for bus_uart_tx: bus responses and serial frames are
// checked by independent monitors against expectations queued by the stimulus.
`timescale 1ns/1ps
module tb_bus_uart_tx;

    localparam logic [31:0] BASE    = 32'h8000_0000;
    localparam logic [15:0] CLK_DIV = 16'd868;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic        bus_rd, bus_wr, bus_ready, txd;
`ifdef BUS_UART_TX_IRQ_EN
    logic        irq;
`endif

    bus_uart_tx dut (
        .clk       (clk),
        .rst       (rst),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_rd    (bus_rd),
        .bus_wr    (bus_wr),
        .bus_rdata (bus_rdata),
        .bus_ready (bus_ready),
`ifdef BUS_UART_TX_IRQ_EN
        .irq       (irq),
`endif
        .txd       (txd)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          chk;
        logic [31:0] exp;
        string       name;
    } resp_t;

    resp_t       rsp_q[$];
    logic [7:0]  tx_q[$];
    logic [15:0] m_div;
    int          tests = 0;
    int          fails = 0;
    int          frames_done = 0;
    bit          mon_in_frame = 0;
    int          mon_pos, mon_errs, mon_first_bad;
    logic [7:0]  mon_byte;
    logic [15:0] mon_div;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference frame: start 0, data LSB first, stop 1; each bit lasts m_div cycles.
    function automatic logic frame_bit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k >= 9) return 1'b1;
        return b[k-1];
    endfunction

    always @(negedge clk) begin : bus_monitor
        resp_t r;
        if (!rst) begin
            if (bus_ready) begin
                if (rsp_q.size() == 0) check("unexpected_ready", bus_ready, 1'b0);
                else begin
                    r = rsp_q.pop_front();
                    if (r.chk) check(r.name, bus_rdata, r.exp);
                end
            end else if (bus_rdata !== 32'd0) begin
                check("rdata_zero_when_idle", bus_rdata, 32'd0);
            end
        end
    end

    always @(negedge clk) begin : tx_monitor
        if (rst) begin
            mon_in_frame = 0;
        end else begin
            if (!mon_in_frame && txd === 1'b0) begin
                if (tx_q.size() == 0) check("unexpected_start_bit", txd, 1'b1);
                else begin
                    mon_byte      = tx_q.pop_front();
                    mon_div       = m_div;
                    mon_in_frame  = 1;
                    mon_pos       = 0;
                    mon_errs      = 0;
                    mon_first_bad = -1;
                end
            end
            if (mon_in_frame) begin
                if (txd !== frame_bit(mon_byte, mon_pos / int'(mon_div))) begin
                    if (mon_errs == 0) mon_first_bad = mon_pos;
                    mon_errs++;
                end
                mon_pos++;
                if (mon_pos == 10 * int'(mon_div)) begin
                    check($sformatf("frame byte=%02h div=%0d bad_cycles(first=%0d)",
                                    mon_byte, mon_div, mon_first_bad), mon_errs, 0);
                    mon_in_frame = 0;
                    frames_done++;
                end
            end
        end
    end

    // Called and returns just after a rising edge; lat = edges from strobe to ready.
    task automatic bus_xfer(input logic [31:0] addr, input bit wr, input logic [31:0] wdata,
                            input bit chk, input logic [31:0] exp, input string name,
                            output int lat);
        resp_t r;
        r.chk = chk; r.exp = exp; r.name = name;
        rsp_q.push_back(r);
        bus_addr = addr; bus_wdata = wdata; bus_wr = wr; bus_rd = !wr;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!bus_ready && lat < 2000);
        if (!bus_ready) begin
            check({name, "_ready_timeout"}, bus_ready, 1'b1);
            rsp_q.delete(rsp_q.size() - 1);
        end
        @(posedge clk); #1;
        bus_rd = 1'b0; bus_wr = 1'b0;
        @(posedge clk); #1;
        lat = lat - 1;
    endtask

    task automatic wr_reg(input logic [3:0] off, input logic [31:0] data);
        int lat;
        bus_xfer(BASE + {28'd0, off}, 1'b1, data, 1'b0, 32'd0, "write", lat);
    endtask

    task automatic rd_reg(input logic [3:0] off, input logic [31:0] exp, input string name);
        int lat;
        bus_xfer(BASE + {28'd0, off}, 1'b0, 32'd0, 1'b1, exp, name, lat);
    endtask

    task automatic send_byte(input logic [7:0] b);
        tx_q.push_back(b);
        wr_reg(4'h0, {24'd0, b});
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while ((tx_q.size() != 0 || mon_in_frame) && n < budget) begin
            @(posedge clk);
            n++;
        end
        check("drain_pending_bytes", tx_q.size(), 0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #500_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int          lat, n, bad;
        logic [15:0] d;

        bus_addr = 32'd0; bus_wdata = 32'd0; bus_rd = 1'b0; bus_wr = 1'b0;
        m_div = CLK_DIV;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_txd", txd, 1'b1);
        check("reset_ready", bus_ready, 1'b0);
        @(posedge clk); #1;

        bus_xfer(BASE + 32'h4, 1'b0, 32'd0, 1'b1, 32'h0000_0002, "status_after_reset", lat);
        check("read_latency", lat, 1);
        rd_reg(4'h8, {16'd0, CLK_DIV}, "divisor_after_reset");
        rd_reg(4'h0, 32'd0, "data_reads_zero");
        rd_reg(4'hC, 32'd0, "irqctl_after_reset");
        check("txd_idle_after_reads", txd, 1'b1);

        wr_reg(4'h8, 32'd4);
        m_div = 16'd4;
        rd_reg(4'h8, 32'd4, "divisor_readback_4");
        tx_q.push_back(8'h55);
        bus_xfer(BASE, 1'b1, 32'hFFFF_FF55, 1'b0, 32'd0, "write", lat);
        check("write_latency", lat, 1);
        wait_drain(200);
        rd_reg(4'h4, 32'h0000_0002, "status_after_drain");

        wr_reg(4'h4, 32'hFFFF_FFFF);
        wr_reg(4'h8, 32'd0);
        m_div = 16'd1;
        rd_reg(4'h8, 32'd1, "divisor_zero_stores_one");
        send_byte(8'($urandom));
        wait_drain(200);

        for (int burst = 0; burst < 6; burst++) begin
            d = 16'($urandom_range(1, 6));
            wr_reg(4'h8, {16'd0, d});
            m_div = d;
            n = $urandom_range(1, 5);
            for (int i = 0; i < n; i++) send_byte(8'($urandom));
            wait_drain(2000);
        end

        // A DIVISOR write while a frame is in flight only affects the next frame.
        wr_reg(4'h8, 32'd3);
        m_div = 16'd3;
        send_byte(8'hC3);
        wr_reg(4'h8, 32'd5);
        m_div = 16'd5;
        send_byte(8'h3C);
        wait_drain(500);

        // The first byte leaves the FIFO at once, so 16 more fill it and the
        // 18th write must wait for the next pop at the end of frame one.
        wr_reg(4'h8, 32'd20);
        m_div = 16'd20;
        for (int i = 0; i < 17; i++) send_byte(8'($urandom));
        rd_reg(4'h4, 32'h0000_1005, "status_full_busy_count16");
        tx_q.push_back(8'hA7);
        bus_xfer(BASE, 1'b1, 32'h0000_00A7, 1'b0, 32'd0, "write", lat);
        check("full_write_withheld", (lat > 20 && lat < 220), 1'b1);
        wait_drain(5000);
        rd_reg(4'h4, 32'h0000_0002, "status_after_full_drain");

        bad = 0;
        bus_addr = BASE + 32'h10; bus_rd = 1'b1;
        repeat (20) begin @(negedge clk); if (bus_ready !== 1'b0 || bus_rdata !== 32'd0) bad++; end
        bus_wr = 1'b1; bus_wdata = 32'h0000_0042;
        repeat (20) begin @(negedge clk); if (bus_ready !== 1'b0 || bus_rdata !== 32'd0) bad++; end
        @(posedge clk); #1;
        bus_rd = 1'b0; bus_wr = 1'b0;
        check("miss_no_response", bad, 0);
        @(posedge clk); #1;

`ifdef BUS_UART_TX_IRQ_EN
        wr_reg(4'h8, 32'd4);
        m_div = 16'd4;
        wr_reg(4'hC, 32'd1);
        @(negedge clk);
        check("irq_idle_enabled", irq, 1'b1);
        @(posedge clk); #1;
        rd_reg(4'hC, 32'd1, "irqctl_readback");
        send_byte(8'h81);
        n = frames_done; bad = 0;
        while (frames_done == n && bad < 1000) begin
            @(posedge clk); #1;
            if (irq !== 1'b0) bad = bad + 1000;
            bad++;
        end
        check("irq_low_while_busy", bad < 1000, 1'b1);
        @(negedge clk);
        check("irq_low_first_idle_cycle", irq, 1'b0);
        @(negedge clk);
        check("irq_high_after_drain", irq, 1'b1);
        @(posedge clk); #1;
`endif

        wr_reg(4'h8, 32'd4);
        m_div = 16'd4;
        send_byte(8'hA5);
        n = 0;
        while (!(mon_in_frame && mon_pos >= 17) && n < 200) begin @(posedge clk); n++; end
        check("mid_frame_reached", mon_in_frame, 1'b1);
        #1 rst = 1'b1;
        tx_q.delete();
        m_div = CLK_DIV;
        @(posedge clk);
        @(negedge clk);
        check("reset_mid_frame_txd", txd, 1'b1);
        check("reset_mid_frame_ready", bus_ready, 1'b0);
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;
        rd_reg(4'h4, 32'h0000_0002, "status_after_mid_reset");
        rd_reg(4'h8, {16'd0, CLK_DIV}, "divisor_after_mid_reset");
        repeat (40) @(posedge clk);

        check("no_outstanding_bus_responses", rsp_q.size(), 0);
        check("no_outstanding_tx_bytes", tx_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
